// File: rtl/video_timing_gen.sv
// Programmable raster timing generator: hs/vs/de plus active-pixel coordinates,
// with a vreset input that snaps the raster to the first active pixel of a frame.
`timescale 1ns/1ps
module video_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned HS_NEG   = 1,
    parameter int unsigned VS_NEG   = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        vreset,
    output logic        hs,
    output logic        vs,
    output logic        de,
    output logic [11:0] x,
    output logic [10:0] y,
    output logic        sof
);

    localparam int unsigned H_W     = 12;
    localparam int unsigned V_W     = 11;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_START = H_SYNC + H_BP;
    localparam int unsigned V_START = V_SYNC + V_BP;
    localparam int unsigned H_END   = H_START + H_ACTIVE;
    localparam int unsigned V_END   = V_START + V_ACTIVE;
    localparam logic        HS_INACT = 1'(HS_NEG);
    localparam logic        VS_INACT = 1'(VS_NEG);

    logic [H_W-1:0] hcnt;
    logic [V_W-1:0] vcnt;
    logic [H_W-1:0] hcnt_nxt_c;
    logic [V_W-1:0] vcnt_nxt_c;
    logic           pending;

    logic           hs_act_c;
    logic           vs_act_c;
    logic           h_in_c;
    logic           v_in_c;
    logic           de_c;
    logic [H_W-1:0] x_c;
    logic [V_W-1:0] y_c;
    logic           sof_c;

    // Next raster position: resync load takes priority over the natural advance
    always_comb begin
        hcnt_nxt_c = hcnt;
        vcnt_nxt_c = vcnt;
        if (pending || vreset) begin
            hcnt_nxt_c = H_W'(H_START);
            vcnt_nxt_c = V_W'(V_START);
        end else if (hcnt == H_W'(H_TOTAL - 1)) begin
            hcnt_nxt_c = '0;
            vcnt_nxt_c = (vcnt == V_W'(V_TOTAL - 1)) ? '0 : vcnt + V_W'(1);
        end else begin
            hcnt_nxt_c = hcnt + H_W'(1);
        end
    end

    // Decode the current (pre-update) counters into output values
    always_comb begin
        hs_act_c = (hcnt < H_W'(H_SYNC));
        vs_act_c = (vcnt < V_W'(V_SYNC));
        h_in_c   = ({1'b0, hcnt} >= (H_W+1)'(H_START)) && ({1'b0, hcnt} < (H_W+1)'(H_END));
        v_in_c   = ({1'b0, vcnt} >= (V_W+1)'(V_START)) && ({1'b0, vcnt} < (V_W+1)'(V_END));
        de_c     = h_in_c && v_in_c;
        x_c      = de_c ? (hcnt - H_W'(H_START)) : '0;
        y_c      = de_c ? (vcnt - V_W'(V_START)) : '0;
        sof_c    = de_c && (x_c == '0) && (y_c == '0);
    end

    // Raster counters and resync request; pending is the only state that moves without ce
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcnt    <= '0;
            vcnt    <= '0;
            pending <= 1'b0;
        end else if (ce) begin
            hcnt    <= hcnt_nxt_c;
            vcnt    <= vcnt_nxt_c;
            pending <= 1'b0;
        end else if (vreset) begin
            pending <= 1'b1;
        end
    end

    // Output registers, one ce edge behind the counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hs  <= HS_INACT;
            vs  <= VS_INACT;
            de  <= 1'b0;
            x   <= '0;
            y   <= '0;
            sof <= 1'b0;
        end else if (ce) begin
            hs  <= hs_act_c ^ HS_INACT;
            vs  <= vs_act_c ^ VS_INACT;
            de  <= de_c;
            x   <= x_c;
            y   <= y_c;
            sof <= sof_c;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen using a small raster (15x8 total, 8x4 active).
`timescale 1ns/1ps
module tb_video_timing_gen;

    localparam int H_ACTIVE = 8;
    localparam int H_FP     = 2;
    localparam int H_SYNC   = 3;
    localparam int H_BP     = 2;
    localparam int V_ACTIVE = 4;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 1;
    localparam int H_TOTAL  = 15;
    localparam int V_TOTAL  = 8;
    localparam int H_START  = 5;
    localparam int V_START  = 3;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [11:0] x;
        logic [10:0] y;
        logic        sof;
    } out_t;

    // hs idles high (HS_NEG=1), vs idles low (VS_NEG=0)
    localparam out_t RST_OUT = '{hs: 1'b1, vs: 1'b0, de: 1'b0, x: 12'd0, y: 11'd0, sof: 1'b0};

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce = 1'b0;
    logic        vreset = 1'b0;
    logic        hs, vs, de, sof;
    logic [11:0] x;
    logic [10:0] y;

    video_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_NEG(1), .VS_NEG(0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .vreset(vreset),
        .hs(hs), .vs(vs), .de(de), .x(x), .y(y), .sof(sof)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   failures = 0;
    out_t sb_q[$];
    out_t exp_last = RST_OUT;
    bit   mon_en = 1'b0;

    // bench-side raster model
    int   mh = 0;
    int   mv = 0;
    bit   mpend = 1'b0;

    // monitor statistics
    int edge_no, sof_cnt, first_sof, last_sof, de_cnt, hs_cnt, vs_cnt, x_max, y_max, hs_after_sof;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic out_t expect_out(input int h, input int v);
        out_t o;
        bit   act;
        act   = (h >= 5) && (h <= 12) && (v >= 3) && (v <= 6);
        o.hs  = (h <= 2) ? 1'b0 : 1'b1;
        o.vs  = (v <= 1) ? 1'b1 : 1'b0;
        o.de  = act;
        o.x   = act ? 12'(h - 5) : 12'd0;
        o.y   = act ? 11'(v - 3) : 11'd0;
        o.sof = act && (h == 5) && (v == 3);
        return o;
    endfunction

    task automatic clear_stats();
        edge_no = 0; sof_cnt = 0; first_sof = 0; last_sof = 0; de_cnt = 0;
        hs_cnt = 0; vs_cnt = 0; x_max = 0; y_max = 0; hs_after_sof = 0;
    endtask

    // Drive one clk cycle from a negedge; predict the response of that posedge
    task automatic step(input bit c, input bit vr);
        ce = c;
        vreset = vr;
        if (c) begin
            sb_q.push_back(expect_out(mh, mv));
            if (mpend || vr) begin
                mh = H_START; mv = V_START; mpend = 1'b0;
            end else if (mh == H_TOTAL - 1) begin
                mh = 0;
                mv = (mv == V_TOTAL - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
        end else if (vr) begin
            mpend = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        mh = 0; mv = 0; mpend = 1'b0;
        sb_q.delete();
        exp_last = RST_OUT;
        clear_stats();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_hs"}, int'(hs), 1);
        chk({tag, "_vs"}, int'(vs), 0);
        chk({tag, "_de"}, int'(de), 0);
        chk({tag, "_x"}, int'(x), 0);
        chk({tag, "_y"}, int'(y), 0);
        chk({tag, "_sof"}, int'(sof), 0);
    endtask

    // Monitor: after each posedge, pop and compare on ce edges, check hold on others
    initial begin : monitor
        bit   ce_s, rn_s;
        out_t got, e;
        forever begin
            @(posedge clk);
            ce_s = ce;
            rn_s = reset_n;
            #1;
            if (rn_s && mon_en) begin
                got = '{hs: hs, vs: vs, de: de, x: x, y: y, sof: sof};
                if (ce_s) begin
                    edge_no++;
                    checks++;
                    if (sb_q.size() == 0) begin
                        failures++;
                        $display("FAIL sb_underflow: got output at ce edge %0d expected none queued", edge_no);
                    end else begin
                        e = sb_q.pop_front();
                        exp_last = e;
                        if (got !== e) begin
                            failures++;
                            $display("FAIL sb_edge%0d: got hs=%b vs=%b de=%b x=%0d y=%0d sof=%b expected hs=%b vs=%b de=%b x=%0d y=%0d sof=%b",
                                     edge_no, got.hs, got.vs, got.de, got.x, got.y, got.sof,
                                     e.hs, e.vs, e.de, e.x, e.y, e.sof);
                        end
                    end
                    if (got.sof) begin
                        sof_cnt++;
                        if (first_sof == 0) first_sof = edge_no;
                        last_sof = edge_no;
                    end
                    if (got.de) begin
                        de_cnt++;
                        if (int'(got.x) > x_max) x_max = int'(got.x);
                        if (int'(got.y) > y_max) y_max = int'(got.y);
                    end
                    if (!got.hs) hs_cnt++;
                    if (got.vs) vs_cnt++;
                    if (!got.hs && first_sof != 0 && hs_after_sof == 0) hs_after_sof = edge_no;
                end else begin
                    checks++;
                    if (got !== exp_last) begin
                        failures++;
                        $display("FAIL hold: got hs=%b de=%b x=%0d y=%0d expected hs=%b de=%b x=%0d y=%0d",
                                 got.hs, got.de, got.x, got.y, exp_last.hs, exp_last.de, exp_last.x, exp_last.y);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        // Power-on reset
        model_reset();
        repeat (2) @(negedge clk);
        chk_reset_outputs("por");
        reset_n = 1'b1;
        mon_en = 1'b1;

        // Free run: exactly two frames from reset
        for (int i = 0; i < 2 * H_TOTAL * V_TOTAL; i++) step(1'b1, 1'b0);
        chk("free_first_sof", first_sof, 51);
        chk("free_sof_cnt", sof_cnt, 2);
        chk("free_last_sof", last_sof, 171);
        chk("free_de_cnt", de_cnt, 64);
        chk("free_hs_cnt", hs_cnt, 48);
        chk("free_vs_cnt", vs_cnt, 60);
        chk("free_x_max", x_max, 7);
        chk("free_y_max", y_max, 3);

        // Mid-frame resync with ce=1
        for (int i = 0; i < 70; i++) step(1'b1, 1'b0);
        clear_stats();
        step(1'b1, 1'b1);
        for (int i = 0; i < 129; i++) step(1'b1, 1'b0);
        chk("mid_first_sof", first_sof, 2);
        chk("mid_hs_after_sof", hs_after_sof, 12);
        chk("mid_sof_cnt", sof_cnt, 2);
        chk("mid_last_sof", last_sof, 122);

        // Resync under ce gating, two pulses between ce edges collapse into one load
        for (int i = 0; i < 80; i++) begin
            if (i == 41) clear_stats();
            step(i % 4 == 0, (i == 41) || (i == 43));
        end
        chk("gate_first_sof", first_sof, 2);
        chk("gate_sof_cnt", sof_cnt, 1);

        // Aligned resync: pulse on the edge that naturally reaches (H_START,V_START)
        for (int i = 0; i < 2 * H_TOTAL * V_TOTAL; i++) begin
            if (mh == H_START - 1 && mv == V_START) break;
            step(1'b1, 1'b0);
        end
        clear_stats();
        step(1'b1, 1'b1);
        for (int i = 0; i < 239; i++) step(1'b1, 1'b0);
        chk("align_first_sof", first_sof, 2);
        chk("align_sof_cnt", sof_cnt, 2);
        chk("align_last_sof", last_sof, 122);

        // Async reset mid-line with a pending request and ce=0
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        #2;
        mon_en = 1'b0;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("async");
        @(negedge clk);
        model_reset();
        reset_n = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 60; i++) step(1'b1, 1'b0);
        chk("post_rst_first_sof", first_sof, 51);
        chk("post_rst_sof_cnt", sof_cnt, 1);

        chk("sb_drain", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Programmable raster timing generator producing hs/vs/de plus active-pixel coordinates for the HDMI output path. It is the counterpart of the hs/vs/de timing analysis on the core side. A single-cycle `vreset` pulse snaps the raster to the first active pixel of a frame, which keeps HDMI generation locked to the Atari ST video. Counters advance only on pixel-enable cycles.

## Interface
- `H_ACTIVE`, 640, active pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, active lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `HS_NEG`, 1, 1 = hs low during sync, 0 = high
- `VS_NEG`, 1, 1 = vs low during sync, 0 = high

Ports:
- `clk` in 1: system clock
- `reset_n` in 1: asynchronous, active-low reset
- `ce` in 1: pixel enable; counters and outputs update only on clk edges with ce=1
- `vreset` in 1: resync request, pulse of ≥1 clk
- `hs` out 1: horizontal sync, polarity per HS_NEG
- `vs` out 1: vertical sync, polarity per VS_NEG
- `de` out 1: active video
- `x` out 12: active column, 0 when de=0
- `y` out 11: active row, 0 when de=0
- `sof` out 1: high for the output cycle of pixel (0,0)

## Operation
- Derived constants:
  - H_TOTAL = sum of the four H params; V_TOTAL likewise.
  - H_START = H_SYNC+H_BP; V_START = V_SYNC+V_BP.
  - Defaults: 800 / 525 / 144 / 35.
- Legal range: H_TOTAL ≤ 4096, V_TOTAL ≤ 2048. Internal counters are hcnt[11:0] and vcnt[10:0].
- Counter origin: hcnt=0 is the first pixel of hsync. vcnt=0 is the first line of vsync.
- Counter update on a ce edge:
  - If hcnt = H_TOTAL-1: hcnt←0, and vcnt ← (vcnt = V_TOTAL-1) ? 0 : vcnt+1.
  - Otherwise hcnt←hcnt+1.
- Decode on a ce edge, from the pre-update counters, into output registers:
  - hs active iff hcnt < H_SYNC.
  - vs active iff vcnt < V_SYNC. vs therefore changes only coincident with hsync start.
  - de = H_START ≤ hcnt < H_START+H_ACTIVE and V_START ≤ vcnt < V_START+V_ACTIVE.
  - x = hcnt-H_START and y = vcnt-V_START when de, else 0.
  - sof = de & x=0 & y=0.
- Resync:
  - Any clk edge with vreset=1 sets `pending`.
  - The next ce edge with (pending | vreset) loads hcnt←H_START and vcnt←V_START instead of incrementing, and clears pending.
  - Output registers on that edge still decode the old counters.
  - A vreset arriving when counters would naturally reach (H_START,V_START) produces an identical raster, with no glitch.
  - Repeated vreset pulses before a ce edge collapse into one load.
- ce=0 edges: every counter and output register holds, except pending.

## Timing
- Reset (asynchronous, immediate) and reset values:
  - hcnt=0, vcnt=0, pending=0.
  - hs and vs inactive: 1 when the _NEG param is 1.
  - de=0, x=0, y=0, sof=0.
- Latency: outputs reflect the counter value one ce edge earlier.
- After reset release with ce=1: the first edge drives hs and vs active.
- Resync latency: the ce edge that applies the load is edge L. Edge L+1 outputs de=1, x=0, y=0, sof=1.
- Vreset sampled on the same edge as ce is applied on that edge. pending stays 0.
- Reset asserted while pending=1 discards the request.
- sof period with free-running ce is exactly H_TOTAL·V_TOTAL ce cycles.

## Test plan
- Free run with defaults, ce=1:
  - First output edge after reset: hs=0, vs=0.
  - hs low 96 cycles per 800.
  - vs low for 2 lines (1600 cycles).
  - 307200 de cycles and one sof per 420000 cycles.
  - First sof at edge 35·800+144+1.
- Mid-frame resync:
  - Pulse vreset for 1 clk with ce=1 at arbitrary position (e.g. hcnt=500, vcnt=300).
  - Next-but-one edge: sof=1, x=0, y=0.
  - de high 640 edges, hs falls 656 edges after sof.
  - Next sof 420000 edges later.
- Resync under ce gating (ce every 4th clk):
  - Pulse vreset for 1 clk between ce edges.
  - Load occurs at the next ce edge; sof follows on the subsequent ce edge.
  - Outputs are stable across non-ce edges.
- Aligned resync:
  - Pulse vreset exactly when counters would reach (144,35).
  - Waveform is identical to the free-run capture; sof period is unchanged.
- Asynchronous reset mid-line with pending=1 (ce=0):
  - Outputs go to reset values without a clk edge.
  - After release with no vreset, the raster restarts from hcnt=0 and no load occurs.
- Parameter override (H_ACTIVE=320, H_SYNC=32, V_ACTIVE=200, VS_NEG=0):
  - Expect 320×200 de per frame.
  - vs high during sync.
  - x max 319, y max 199.
